// File: rtl/time_report_tx_pkg.sv
// rtl/time_report_tx_pkg.sv - shared constants and types for the time report transmitter
package time_report_tx_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_DOT   = 8'h2E;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_S     = 8'h53;
    localparam logic [7:0] ASCII_W     = 8'h57;

    localparam logic [6:0] DIGIT_CLAMP = 7'd99;

    // Position of each character within the transmitted line.
    localparam logic [3:0] IDX_PREFIX = 4'd0;
    localparam logic [3:0] IDX_HOUR_T = 4'd1;
    localparam logic [3:0] IDX_HOUR_O = 4'd2;
    localparam logic [3:0] IDX_COLON0 = 4'd3;
    localparam logic [3:0] IDX_MIN_T  = 4'd4;
    localparam logic [3:0] IDX_MIN_O  = 4'd5;
    localparam logic [3:0] IDX_COLON1 = 4'd6;
    localparam logic [3:0] IDX_SEC_T  = 4'd7;
    localparam logic [3:0] IDX_SEC_O  = 4'd8;
    localparam logic [3:0] IDX_DOT    = 4'd9;
    localparam logic [3:0] IDX_CS_T   = 4'd10;
    localparam logic [3:0] IDX_CS_O   = 4'd11;
    localparam logic [3:0] IDX_EOL0   = 4'd12;
    localparam logic [3:0] IDX_EOL1   = 4'd13;

    function automatic logic [3:0] last_idx(input bit crlf);
        return crlf ? IDX_EOL1 : IDX_EOL0;
    endfunction

endpackage

// File: rtl/time_report_tx_bin2ascii2.sv
// rtl/time_report_tx_bin2ascii2.sv - binary 0..127 to two ASCII decimal digits, clamped at 99
module time_report_tx_bin2ascii2
    import time_report_tx_pkg::*;
(
    input  logic [6:0] bin_i,
    output logic [7:0] tens_o,
    output logic [7:0] ones_o
);

    logic [6:0] val;
    logic [3:0] tens;
    logic [3:0] ones;

    // Tens found by threshold comparison; ones is the remainder after the largest decade fits.
    always_comb begin
        val  = (bin_i > DIGIT_CLAMP) ? DIGIT_CLAMP : bin_i;
        tens = 4'd0;
        ones = 4'(val);
        for (int k = 1; k < 10; k++) begin
            if (val >= 7'(k * 10)) begin
                tens = 4'(k);
                ones = 4'(val - 7'(k * 10));
            end
        end
    end

    assign tens_o = ASCII_ZERO + {4'd0, tens};
    assign ones_o = ASCII_ZERO + {4'd0, ones};

endmodule

// File: rtl/time_report_tx.sv
// rtl/time_report_tx.sv - snapshots the time and pushes "<P>HH:MM:SS.CC<EOL>" into the UART TX FIFO
module time_report_tx
    import time_report_tx_pkg::*;
#(
    parameter bit         EOL_CRLF  = 1'b1,
    parameter logic [7:0] PREFIX_SW = ASCII_S,
    parameter logic [7:0] PREFIX_W  = ASCII_W
)(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_req,
    input  logic       i_sel_m,
    input  logic [4:0] i_hour,
    input  logic [5:0] i_min,
    input  logic [5:0] i_sec,
    input  logic [6:0] i_cs,
    input  logic       tx_fifo_full,
    output logic       o_push,
    output logic [7:0] o_push_data,
    output logic       o_busy
);

    localparam logic [3:0] LAST = last_idx(EOL_CRLF);

    state_t     state_q;
    logic [3:0] idx_q;
    logic       pending_q;
    logic       sel_q;
    logic [4:0] hour_q;
    logic [5:0] min_q;
    logic [5:0] sec_q;
    logic [6:0] cs_q;

    logic       push;
    logic [7:0] byte_sel;
    logic [7:0] hour_t, hour_o, min_t, min_o, sec_t, sec_o, cs_t, cs_o;

    assign push = (state_q == ST_SEND) && !tx_fifo_full;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= 4'd0;
            pending_q <= 1'b0;
            sel_q     <= 1'b0;
            hour_q    <= 5'd0;
            min_q     <= 6'd0;
            sec_q     <= 6'd0;
            cs_q      <= 7'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_req || pending_q) begin
                        state_q   <= ST_SEND;
                        idx_q     <= 4'd0;
                        pending_q <= 1'b0;
                        sel_q     <= i_sel_m;
                        hour_q    <= i_hour;
                        min_q     <= i_min;
                        sec_q     <= i_sec;
                        cs_q      <= i_cs;
                    end
                end
                ST_SEND: begin
                    // Any request seen mid-frame collapses into one follow-up frame.
                    if (i_req) begin
                        pending_q <= 1'b1;
                    end
                    if (push) begin
                        if (idx_q == LAST) begin
                            state_q <= ST_IDLE;
                            idx_q   <= 4'd0;
                        end else begin
                            idx_q <= idx_q + 4'd1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    time_report_tx_bin2ascii2 u_hour (.bin_i({2'd0, hour_q}), .tens_o(hour_t), .ones_o(hour_o));
    time_report_tx_bin2ascii2 u_min  (.bin_i({1'd0, min_q}),  .tens_o(min_t),  .ones_o(min_o));
    time_report_tx_bin2ascii2 u_sec  (.bin_i({1'd0, sec_q}),  .tens_o(sec_t),  .ones_o(sec_o));
    time_report_tx_bin2ascii2 u_cs   (.bin_i(cs_q),           .tens_o(cs_t),   .ones_o(cs_o));

    always_comb begin
        byte_sel = 8'h00;
        case (idx_q)
            IDX_PREFIX: byte_sel = sel_q ? PREFIX_W : PREFIX_SW;
            IDX_HOUR_T: byte_sel = hour_t;
            IDX_HOUR_O: byte_sel = hour_o;
            IDX_COLON0: byte_sel = ASCII_COLON;
            IDX_MIN_T:  byte_sel = min_t;
            IDX_MIN_O:  byte_sel = min_o;
            IDX_COLON1: byte_sel = ASCII_COLON;
            IDX_SEC_T:  byte_sel = sec_t;
            IDX_SEC_O:  byte_sel = sec_o;
            IDX_DOT:    byte_sel = ASCII_DOT;
            IDX_CS_T:   byte_sel = cs_t;
            IDX_CS_O:   byte_sel = cs_o;
            IDX_EOL0:   byte_sel = EOL_CRLF ? ASCII_CR : ASCII_LF;
            IDX_EOL1:   byte_sel = ASCII_LF;
            default:    byte_sel = 8'h00;
        endcase
    end

    assign o_push      = push;
    assign o_push_data = push ? byte_sel : 8'h00;
    assign o_busy      = (state_q == ST_SEND);

endmodule

// File: tb/tb_time_report_tx.sv
// tb/tb_time_report_tx.sv - randomized self-checking bench for time_report_tx
module tb_time_report_tx;

    logic       clk = 1'b0;
    logic       rst, i_req, i_sel_m, tx_fifo_full;
    logic [4:0] i_hour;
    logic [5:0] i_min, i_sec;
    logic [6:0] i_cs;
    logic       o_push, o_busy, l_push, l_busy;
    logic [7:0] o_push_data, l_push_data;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int busy_cnt = 0;
    logic [7:0] cap[$];
    int         cap_cyc[$];
    logic [7:0] capl[$];

    time_report_tx dut (
        .clk(clk), .rst(rst), .i_req(i_req), .i_sel_m(i_sel_m), .i_hour(i_hour),
        .i_min(i_min), .i_sec(i_sec), .i_cs(i_cs), .tx_fifo_full(tx_fifo_full),
        .o_push(o_push), .o_push_data(o_push_data), .o_busy(o_busy)
    );

    time_report_tx #(.EOL_CRLF(1'b0)) dut_lf (
        .clk(clk), .rst(rst), .i_req(i_req), .i_sel_m(i_sel_m), .i_hour(i_hour),
        .i_min(i_min), .i_sec(i_sec), .i_cs(i_cs), .tx_fifo_full(tx_fifo_full),
        .o_push(l_push), .o_push_data(l_push_data), .o_busy(l_busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (o_push) begin
            cap.push_back(o_push_data);
            cap_cyc.push_back(cyc);
        end
        if (l_push) capl.push_back(l_push_data);
        if (o_busy) busy_cnt++;
        cyc++;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int clamp99(input int v);
        return (v > 99) ? 99 : v;
    endfunction

    function automatic string model_line(input bit sel, input int h, input int m,
                                         input int s, input int c, input bit crlf);
        string p;
        string e;
        if (sel) p = "W"; else p = "S";
        if (crlf) e = "\r\n"; else e = "\n";
        return $sformatf("%s%02d:%02d:%02d.%02d%s", p, clamp99(h), clamp99(m),
                         clamp99(s), clamp99(c), e);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        cap.delete();
        cap_cyc.delete();
        capl.delete();
        busy_cnt = 0;
    endtask

    task automatic set_time(input int h, input int m, input int s, input int c, input bit sel);
        i_hour  = 5'(h);
        i_min   = 6'(m);
        i_sec   = 6'(s);
        i_cs    = 7'(c);
        i_sel_m = sel;
    endtask

    task automatic wait_bytes(input int n, input int bound, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < bound; k++) begin
            if (cap.size() >= n) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; i_req = 1'b0; tx_fifo_full = 1'b0;
        set_time(0, 0, 0, 0, 0);
        #2 rst = 1'b0;
        tick(); tick();
        n_tests++; if (o_push !== 1'b0) begin n_fail++; $display("FAIL reset_push got %b want 0", o_push); end
        n_tests++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", o_busy); end
        n_tests++; if (o_push_data !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h want 00", o_push_data); end
        n_tests++; if (l_push !== 1'b0 || l_busy !== 1'b0) begin n_fail++; $display("FAIL reset_lf got %b%b want 00", l_push, l_busy); end
        rst = 1'b1;
        tick(); tick();
        n_tests++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL idle_no_req busy got %b want 0", o_busy); end
    endtask

    task automatic test_basic();
        string exp;
        int req_cyc;
        bit ok;
        exp = model_line(0, 12, 34, 56, 78, 1);
        set_time(12, 34, 56, 78, 0);
        clear_mon();
        i_req = 1'b1; tick(); i_req = 1'b0;
        req_cyc = cyc;
        wait_bytes(14, 40, ok);
        tick(); tick(); tick();
        n_tests++; if (!ok || cap.size() != 14) begin n_fail++; $display("FAIL basic_len got %0d want 14", cap.size()); end
        for (int i = 0; i < 14 && i < cap.size(); i++) begin
            n_tests++;
            if (cap[i] !== 8'(exp[i])) begin n_fail++; $display("FAIL basic_byte%0d got %h want %h", i, cap[i], 8'(exp[i])); end
        end
        if (cap.size() == 14) begin
            n_tests++; if (cap_cyc[0] != req_cyc) begin n_fail++; $display("FAIL basic_latency got %0d want %0d", cap_cyc[0], req_cyc); end
            n_tests++; if (cap_cyc[13] - cap_cyc[0] != 13) begin n_fail++; $display("FAIL basic_span got %0d want 13", cap_cyc[13] - cap_cyc[0]); end
        end
        n_tests++; if (busy_cnt != 14) begin n_fail++; $display("FAIL basic_busy got %0d want 14", busy_cnt); end
    endtask

    task automatic test_full();
        string exp;
        bit ok;
        exp = model_line(0, 12, 34, 56, 78, 1);
        set_time(12, 34, 56, 78, 0);
        clear_mon();
        i_req = 1'b1; tick(); i_req = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        tx_fifo_full = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_tests++; if (o_push !== 1'b0) begin n_fail++; $display("FAIL full_push%0d got %b want 0", k, o_push); end
            tick();
        end
        tx_fifo_full = 1'b0;
        wait_bytes(14, 40, ok);
        tick(); tick();
        n_tests++; if (!ok || cap.size() != 14) begin n_fail++; $display("FAIL full_len got %0d want 14", cap.size()); end
        for (int i = 0; i < 14 && i < cap.size(); i++) begin
            n_tests++;
            if (cap[i] !== 8'(exp[i])) begin n_fail++; $display("FAIL full_byte%0d got %h want %h", i, cap[i], 8'(exp[i])); end
        end
        if (cap.size() == 14) begin
            n_tests++; if (cap_cyc[5] - cap_cyc[4] != 4) begin n_fail++; $display("FAIL full_gap got %0d want 4", cap_cyc[5] - cap_cyc[4]); end
            n_tests++; if (cap_cyc[13] - cap_cyc[0] != 16) begin n_fail++; $display("FAIL full_span got %0d want 16", cap_cyc[13] - cap_cyc[0]); end
        end
        n_tests++; if (busy_cnt != 17) begin n_fail++; $display("FAIL full_busy got %0d want 17", busy_cnt); end
    endtask

    task automatic test_pending();
        string exp;
        bit ok;
        exp = {model_line(0, 12, 34, 56, 78, 1), model_line(0, 1, 2, 3, 4, 1)};
        set_time(12, 34, 56, 78, 0);
        clear_mon();
        i_req = 1'b1; tick(); i_req = 1'b0;
        tick(); tick();
        for (int k = 0; k < 3; k++) begin
            if (k == 2) set_time(1, 2, 3, 4, 0);
            i_req = 1'b1; tick(); i_req = 1'b0;
            tick();
        end
        wait_bytes(28, 80, ok);
        for (int k = 0; k < 20; k++) tick();
        n_tests++; if (!ok || cap.size() != 28) begin n_fail++; $display("FAIL pend_len got %0d want 28", cap.size()); end
        for (int i = 0; i < 28 && i < cap.size(); i++) begin
            n_tests++;
            if (cap[i] !== 8'(exp[i])) begin n_fail++; $display("FAIL pend_byte%0d got %h want %h", i, cap[i], 8'(exp[i])); end
        end
        if (cap.size() == 28) begin
            n_tests++; if (cap_cyc[14] - cap_cyc[13] != 2) begin n_fail++; $display("FAIL pend_idle_gap got %0d want 2", cap_cyc[14] - cap_cyc[13]); end
        end
    endtask

    task automatic test_clamp_and_lf();
        string exp;
        string expl;
        bit ok;
        int n_cr;
        exp = model_line(1, 0, 59, 0, 127, 1);
        set_time(0, 59, 0, 127, 1);
        clear_mon();
        i_req = 1'b1; tick(); i_req = 1'b0;
        wait_bytes(14, 40, ok);
        tick(); tick();
        n_tests++; if (!ok || cap.size() != 14) begin n_fail++; $display("FAIL clamp_len got %0d want 14", cap.size()); end
        for (int i = 0; i < 14 && i < cap.size(); i++) begin
            n_tests++;
            if (cap[i] !== 8'(exp[i])) begin n_fail++; $display("FAIL clamp_byte%0d got %h want %h", i, cap[i], 8'(exp[i])); end
        end
        expl = model_line(0, 0, 0, 0, 0, 0);
        set_time(0, 0, 0, 0, 0);
        clear_mon();
        i_req = 1'b1; tick(); i_req = 1'b0;
        wait_bytes(14, 40, ok);
        tick(); tick();
        n_tests++; if (capl.size() != 13) begin n_fail++; $display("FAIL lf_len got %0d want 13", capl.size()); end
        n_cr = 0;
        for (int i = 0; i < capl.size(); i++) begin
            if (capl[i] == 8'h0D) n_cr++;
            if (i < 13) begin
                n_tests++;
                if (capl[i] !== 8'(expl[i])) begin n_fail++; $display("FAIL lf_byte%0d got %h want %h", i, capl[i], 8'(expl[i])); end
            end
        end
        n_tests++; if (n_cr != 0) begin n_fail++; $display("FAIL lf_no_cr got %0d want 0", n_cr); end
    endtask

    task automatic test_reset_mid();
        string exp;
        bit ok;
        set_time(9, 8, 7, 6, 1);
        clear_mon();
        i_req = 1'b1; tick(); i_req = 1'b0;
        tick();
        i_req = 1'b1; tick(); i_req = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        #2 rst = 1'b0;
        #1;
        n_tests++; if (o_push !== 1'b0) begin n_fail++; $display("FAIL rstmid_push got %b want 0", o_push); end
        n_tests++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got %b want 0", o_busy); end
        n_tests++; if (cap.size() != 7) begin n_fail++; $display("FAIL rstmid_bytes_before got %0d want 7", cap.size()); end
        tick(); tick();
        rst = 1'b1;
        for (int k = 0; k < 20; k++) tick();
        n_tests++; if (cap.size() != 7) begin n_fail++; $display("FAIL rstmid_no_pending got %0d want 7", cap.size()); end
        exp = model_line(0, 23, 45, 1, 99, 1);
        set_time(23, 45, 1, 99, 0);
        clear_mon();
        i_req = 1'b1; tick(); i_req = 1'b0;
        wait_bytes(14, 40, ok);
        tick(); tick();
        n_tests++; if (!ok || cap.size() != 14) begin n_fail++; $display("FAIL rstmid_len got %0d want 14", cap.size()); end
        for (int i = 0; i < 14 && i < cap.size(); i++) begin
            n_tests++;
            if (cap[i] !== 8'(exp[i])) begin n_fail++; $display("FAIL rstmid_byte%0d got %h want %h", i, cap[i], 8'(exp[i])); end
        end
    endtask

    task automatic test_random();
        string exp;
        int h, m, s, c;
        bit sel;
        bit done;
        for (int it = 0; it < 10; it++) begin
            h = $urandom_range(0, 31); m = $urandom_range(0, 63);
            s = $urandom_range(0, 63); c = $urandom_range(0, 127);
            sel = 1'($urandom_range(0, 1));
            exp = model_line(sel, h, m, s, c, 1);
            set_time(h, m, s, c, sel);
            clear_mon();
            tx_fifo_full = 1'($urandom_range(0, 1));
            i_req = 1'b1; tick(); i_req = 1'b0;
            set_time($urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 63),
                     $urandom_range(0, 127), 1'($urandom_range(0, 1)));
            done = 1'b0;
            for (int k = 0; k < 300; k++) begin
                if (cap.size() >= 14) begin done = 1'b1; break; end
                tx_fifo_full = ($urandom_range(0, 2) == 0);
                tick();
            end
            tx_fifo_full = 1'b0;
            tick(); tick(); tick();
            n_tests++; if (!done || cap.size() != 14) begin n_fail++; $display("FAIL rand%0d_len got %0d want 14", it, cap.size()); end
            for (int i = 0; i < 14 && i < cap.size(); i++) begin
                n_tests++;
                if (cap[i] !== 8'(exp[i])) begin n_fail++; $display("FAIL rand%0d_byte%0d got %h want %h", it, i, cap[i], 8'(exp[i])); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_pending();
        test_clamp_and_lf();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
